// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // A requested ratio of 0 behaves exactly like a ratio of 1.
    function automatic logic [31:0] div_eff(input logic [31:0] n);
        return (n == 32'd0) ? 32'd1 : n;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow ratio+mode, pending flag and
// registered clk_out/tick.  A shadow config becomes active only at a period boundary.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 30,
    parameter int DEFAULT_DIV = 50000000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             restart_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic             cfg_mode_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             pending_o
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(div_eff(32'(DEFAULT_DIV)));

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] sh_div_q, sh_div_d;
    logic             mode_q, mode_d;
    logic             sh_mode_q, sh_mode_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [DIV_W-1:0] new_div;
    logic             tc;

    assign new_div = DIV_W'(div_eff(32'(cfg_div_i)));
    // >= rather than == keeps the counter bounded even if div ever shrank under it.
    assign tc      = (cnt_q >= div_q - DIV_W'(1));

    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        mode_d    = mode_q;
        sh_div_d  = sh_div_q;
        sh_mode_d = sh_mode_q;
        pend_d    = pend_q;
        clk_d     = clk_q;
        tick_d    = 1'b0;
        if (restart_i) begin
            cnt_d  = '0;
            clk_d  = 1'b0;
            pend_d = 1'b0;
            if (load_i) begin
                div_d  = new_div;
                mode_d = cfg_mode_i;
            end else if (pend_q) begin
                div_d  = sh_div_q;
                mode_d = sh_mode_q;
            end
        end else if (!en_i) begin
            cnt_d  = '0;
            clk_d  = 1'b0;
            pend_d = 1'b0;
            if (pend_q) begin
                div_d  = sh_div_q;
                mode_d = sh_mode_q;
            end
            if (load_i) begin
                sh_div_d  = new_div;
                sh_mode_d = cfg_mode_i;
                pend_d    = 1'b1;
            end
        end else begin
            if (tc) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (pend_q) begin
                    div_d  = sh_div_q;
                    mode_d = sh_mode_q;
                    pend_d = 1'b0;
                end
                // Toggle only while both the old and the new mode are TOGGLE.
                clk_d = (mode_q == MODE_TOGGLE && mode_d == MODE_TOGGLE) ? ~clk_q : 1'b0;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
            if (load_i) begin
                sh_div_d  = new_div;
                sh_mode_d = cfg_mode_i;
                pend_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            div_q     <= DIV_RST;
            mode_q    <= MODE_TOGGLE;
            sh_div_q  <= DIV_RST;
            sh_mode_q <= MODE_TOGGLE;
            pend_q    <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            mode_q    <= mode_d;
            sh_div_q  <= sh_div_d;
            sh_mode_q <= sh_mode_d;
            pend_q    <= pend_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator.  Config handshake:
// a transfer happens on a posedge where cfg_valid & cfg_ready; cfg_ready drops while the target channel holds a pending config.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int  NCH         = 4,
    parameter int  DIV_W       = 30,
    parameter int  DEFAULT_DIV = 50000000,
    localparam int CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             inclk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_chan,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_mode,
    input  logic [NCH-1:0]   ch_en,
    input  logic             sync_restart,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
);

    logic [NCH-1:0] pend;
    logic [NCH-1:0] load;

    // Out-of-range channels match no index, so they stay ready and load nothing.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_chan == CH_W'(i)) cfg_ready = ~pend[i];
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        assign load[g] = cfg_valid & cfg_ready & (cfg_chan == CH_W'(g));

        clk_div_chan #(
            .DIV_W      (DIV_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_chan (
            .clk_i     (inclk),
            .rst_ni    (rst_n),
            .en_i      (ch_en[g]),
            .restart_i (sync_restart),
            .load_i    (load[g]),
            .cfg_div_i (cfg_div),
            .cfg_mode_i(cfg_mode),
            .clk_out_o (clk_out[g]),
            .tick_o    (tick[g]),
            .pending_o (pend[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed plus randomized bench for clk_div_multi (NCH=2, DIV_W=8, DEFAULT_DIV=3).
module tb_clk_div_multi;

    logic       inclk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [0:0] cfg_chan;
    logic [7:0] cfg_div;
    logic       cfg_mode;
    logic [1:0] ch_en;
    logic       sync_restart;
    logic [1:0] clk_out;
    logic [1:0] tick;

    int checks = 0;
    int errors = 0;

    // Reference model state, one entry per channel.
    int m_cnt[2];
    int m_div[2];
    int m_sh_div[2];
    bit m_mode[2];
    bit m_sh_mode[2];
    bit m_pend[2];
    bit m_clk[2];
    bit m_tick[2];

    always #5 inclk = ~inclk;

    clk_div_multi #(
        .NCH        (2),
        .DIV_W      (8),
        .DEFAULT_DIV(3)
    ) dut (
        .inclk       (inclk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_chan    (cfg_chan),
        .cfg_div     (cfg_div),
        .cfg_mode    (cfg_mode),
        .ch_en       (ch_en),
        .sync_restart(sync_restart),
        .clk_out     (clk_out),
        .tick        (tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0;    m_div[i] = 3;     m_sh_div[i] = 3;
            m_mode[i] = 0;   m_sh_mode[i] = 0; m_pend[i] = 0;
            m_clk[i] = 0;    m_tick[i] = 0;
        end
    endtask

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    // One clock of the spec rules, applied to the inputs present at this edge.
    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            bit acc;
            bit nmode;
            int ndiv;
            acc = cfg_valid && (int'(cfg_chan) == i) && !m_pend[i];
            if (sync_restart) begin
                m_cnt[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
                if (acc) begin
                    m_div[i] = eff(int'(cfg_div)); m_mode[i] = cfg_mode;
                end else if (m_pend[i]) begin
                    m_div[i] = m_sh_div[i]; m_mode[i] = m_sh_mode[i];
                end
                m_pend[i] = 0;
            end else if (!ch_en[i]) begin
                m_cnt[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
                if (m_pend[i]) begin
                    m_div[i] = m_sh_div[i]; m_mode[i] = m_sh_mode[i];
                end
                m_pend[i] = 0;
                if (acc) begin
                    m_sh_div[i] = eff(int'(cfg_div)); m_sh_mode[i] = cfg_mode; m_pend[i] = 1;
                end
            end else begin
                if (m_cnt[i] == m_div[i] - 1) begin
                    nmode = m_pend[i] ? m_sh_mode[i] : m_mode[i];
                    ndiv  = m_pend[i] ? m_sh_div[i] : m_div[i];
                    m_clk[i]  = (m_mode[i] == 0 && nmode == 0) ? !m_clk[i] : 1'b0;
                    m_div[i]  = ndiv;
                    m_mode[i] = nmode;
                    m_pend[i] = 0;
                    m_cnt[i]  = 0;
                    m_tick[i] = 1;
                end else begin
                    m_cnt[i]++;
                    m_tick[i] = 0;
                end
                if (acc) begin
                    m_sh_div[i] = eff(int'(cfg_div)); m_sh_mode[i] = cfg_mode; m_pend[i] = 1;
                end
            end
        end
    endtask

    // Called just after a negedge with inputs already set.
    task automatic cyc();
        #1;
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend[cfg_chan]));
        @(posedge inclk);
        model_update();
        @(negedge inclk);
        chk("clk_out", 32'(clk_out), 32'({m_clk[1], m_clk[0]}));
        chk("tick", 32'(tick), 32'({m_tick[1], m_tick[0]}));
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tk;
        int ck;
        int tg;
        bit prev;
        bit aligned;

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_chan = '0; cfg_div = '0;
        cfg_mode = 1'b0; ch_en = 2'b00; sync_restart = 1'b0;
        model_reset();
        #12;
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_ready", 32'(cfg_ready), 1);

        // Default ratio 3: ticks at cycles 3,6,9,12; clk_out period 6.
        @(negedge inclk);
        rst_n = 1'b1; ch_en = 2'b11;
        tk = 0; ck = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            tk += int'(tick[0]);
            ck += int'(clk_out[0]);
        end
        chk("def_tick_count", tk, 4);
        chk("def_clk_high", ck, 6);

        // ch1 -> div 5 PULSE while running.
        cfg_valid = 1'b1; cfg_chan = 1'b1; cfg_div = 8'd5; cfg_mode = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        for (int k = 0; k < 20; k++) cyc();
        chk("pulse_clk_low", 32'(clk_out[1]), 0);

        // ch0 -> div 0 (behaves as 1).
        cfg_valid = 1'b1; cfg_chan = 1'b0; cfg_div = 8'd0; cfg_mode = 1'b0;
        cyc();
        cfg_valid = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        tk = 0; tg = 0; prev = clk_out[0];
        for (int k = 0; k < 4; k++) begin
            cyc();
            tk += int'(tick[0]);
            tg += int'(clk_out[0] != prev);
            prev = clk_out[0];
        end
        chk("div1_tick_count", tk, 4);
        chk("div1_toggles", tg, 4);

        // Back to 3, then accept a new ratio exactly on a terminal count.
        cfg_valid = 1'b1; cfg_chan = 1'b0; cfg_div = 8'd3;
        cyc();
        cfg_valid = 1'b0;
        for (int k = 0; k < 10 && !(m_cnt[0] == 2 && !m_pend[0]); k++) cyc();
        aligned = (m_cnt[0] == 2) && !m_pend[0];
        checks++;
        assert (aligned) else begin
            errors++;
            $error("FAIL tc_wait: observed %0d expected %0d", aligned, 1);
        end
        cfg_valid = 1'b1; cfg_div = 8'd4;
        cyc();
        chk("tc_accept_tick", 32'(tick[0]), 1);
        cfg_valid = 1'b0;
        cyc();
        chk("ready_low_pending", 32'(cfg_ready), 0);
        for (int k = 0; k < 12; k++) cyc();

        // ch1 disabled mid-count then re-enabled: first tick after 5 cycles.
        for (int k = 0; k < 2; k++) cyc();
        ch_en = 2'b01;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("off_outputs", 32'({clk_out[1], tick[1]}), 0);
        end
        ch_en = 2'b11;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk("reen_tick", 32'(tick[1]), (k == 5) ? 1 : 0);
        end

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            cfg_valid    = ($urandom_range(0, 2) == 0);
            cfg_chan     = 1'($urandom_range(0, 1));
            cfg_div      = 8'($urandom_range(0, 7));
            cfg_mode     = 1'($urandom_range(0, 1));
            sync_restart = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) ch_en[$urandom_range(0, 1)] ^= 1'b1;
            cyc();
        end
        cfg_valid = 1'b0; sync_restart = 1'b0; ch_en = 2'b11;
        for (int k = 0; k < 7; k++) cyc();

        // sync_restart together with a config accept on ch1.
        sync_restart = 1'b1; cfg_valid = 1'b1; cfg_chan = 1'b1; cfg_div = 8'd2; cfg_mode = 1'b0;
        cyc();
        sync_restart = 1'b0; cfg_valid = 1'b0;
        chk("restart_outputs", 32'({clk_out, tick}), 0);
        for (int k = 0; k < 8; k++) cyc();

        // Asynchronous reset in the middle of a cycle.
        @(posedge inclk);
        model_update();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_clk_out", 32'(clk_out), 0);
        chk("async_tick", 32'(tick), 0);
        chk("async_ready", 32'(cfg_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
